// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - WIDTH-bit registered bitwise logic unit with 2-entry skid output buffer
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake (in_ready is decoded from registered state only)
//   op, a, b              gate select and operands (b ignored for NOT/BUF)
//   out_valid/out_ready   output handshake
//   y, y_zero, y_par      registered result, zero flag, XOR-reduction parity
//   xfer_cnt              saturating count of output transfers
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_par,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] skid_y;
    logic             skid_zero;
    logic             skid_par;
    logic             in_fire;
    logic             out_fire;
    logic             load_out_new;
    logic             load_out_skid;
    logic             load_skid;

    always_comb begin
        res = '0;
        unique case (op)
            3'b000: res = ~a;
            3'b001: res = a & b;
            3'b010: res = a | b;
            3'b011: res = a ^ b;
            3'b100: res = ~(a & b);
            3'b101: res = ~(a | b);
            3'b110: res = ~(a ^ b);
            3'b111: res = a;
            default: res = '0;
        endcase
    end

    assign in_ready  = (state_q != S_TWO);
    assign out_valid = (state_q != S_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    state_d      = S_ONE;
                    load_out_new = 1'b1;
                end
            end
            S_ONE: begin
                if (in_fire && out_fire) begin
                    load_out_new = 1'b1;
                end else if (in_fire) begin
                    state_d   = S_TWO;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                // Skid entry is older than anything that could arrive, so it moves up first.
                if (out_fire) begin
                    state_d       = S_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y      <= '0;
            y_zero <= 1'b0;
            y_par  <= 1'b0;
        end else if (load_out_new) begin
            y      <= res;
            y_zero <= (res == '0);
            y_par  <= ^res;
        end else if (load_out_skid) begin
            y      <= skid_y;
            y_zero <= skid_zero;
            y_par  <= skid_par;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_y    <= '0;
            skid_zero <= 1'b0;
            skid_par  <= 1'b0;
        end else if (load_skid) begin
            skid_y    <= res;
            skid_zero <= (res == '0);
            skid_par  <= ^res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (out_fire && (xfer_cnt != {CNT_W{1'b1}})) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

endmodule
